cordic_cs_rotator: RTL and testbench

- Iterative CORDIC rotation-mode engine that keeps the residual angle Z in carry-save form (VS, VC).
- Each iteration it presents Z to the downstream sign detector, waits for the registered sign, then applies one micro-rotation.
- Acts as both feeder and consumer of the sign detector; X/Y stay in conventional two's complement.
- Sits between the pipeline input register and the output/gain stage.

---
 rtl/cordic_cs_rotator_pkg.sv | 47 ++++
 rtl/cordic_cs_rotator_if.sv | 40 ++++
 rtl/cordic_cs_rotator_csa32.sv | 24 ++
 rtl/cordic_cs_rotator.sv | 181 ++++++++++++++++++
 tb/tb_cordic_cs_rotator.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_cs_rotator_pkg.sv
//------------------------------------------------------------------------------
// Module   : cordic_pkg
// Brief    : Shared constants, arctangent table and FSM state type for the
//            carry-save CORDIC rotator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cordic_pkg;

    // Default datapath width, Q2.14 two's complement.
    localparam int C_WIDTH = 16;

    // Number of entries in the arctangent table (upper bound for ITER).
    localparam int C_ATAN_N = 12;

    // Rotator control states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        COMP = 3'd3,
        DONE = 3'd4
    } state_t;

    // atan(2^-i) in Q2.14; indices past the table return zero.
    function automatic logic [15:0] atan_q14(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd12868;
            4'd1:    return 16'd7596;
            4'd2:    return 16'd4014;
            4'd3:    return 16'd2037;
            4'd4:    return 16'd1023;
            4'd5:    return 16'd512;
            4'd6:    return 16'd256;
            4'd7:    return 16'd128;
            4'd8:    return 16'd64;
            4'd9:    return 16'd32;
            4'd10:   return 16'd16;
            4'd11:   return 16'd8;
            default: return 16'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_cs_rotator_if.sv
//------------------------------------------------------------------------------
// Module   : cordic_cs_rotator_if
// Brief    : Link between the rotator and the downstream sign detector. The
//            rotator is master (drives the carry-save Z and its strobe), the
//            detector is slave (returns the registered sign).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cordic_cs_rotator_if
    import cordic_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) ();

    logic [WIDTH-1:0] sd_vs;
    logic [WIDTH-1:0] sd_vc;
    logic             sd_valid;
    logic             sd_sgn;
    logic             sd_done;

    modport master (
        output sd_vs,
        output sd_vc,
        output sd_valid,
        input  sd_sgn,
        input  sd_done
    );

    modport slave (
        input  sd_vs,
        input  sd_vc,
        input  sd_valid,
        output sd_sgn,
        output sd_done
    );

endinterface

`default_nettype wire

// File: rtl/cordic_cs_rotator_csa32.sv
//------------------------------------------------------------------------------
// Module   : csa32
// Brief    : Bitwise 3:2 compressor. carry is the unshifted majority vector;
//            the caller applies the weight-2 shift.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csa32 #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0]      sum,
    output logic [WIDTH-1:0]      carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/cordic_cs_rotator.sv
//------------------------------------------------------------------------------
// Module   : cordic_cs_rotator
// Brief    : Iterative rotation-mode CORDIC. The residual angle is kept in
//            carry-save form (VS, VC); each iteration the pair is handed to an
//            external sign detector and the returned sign steers one
//            micro-rotation of X/Y and a 3:2 compression of Z.
// Config   : define SCALE_COMP_EN to add a COMP state that multiplies X/Y by
//            ~0.60742 (inverse CORDIC gain) before DONE.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cordic_cs_rotator
    import cordic_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int ITER  = 12
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] x_in,
    input  wire logic [WIDTH-1:0] y_in,
    input  wire logic [WIDTH-1:0] z_in,
    cordic_cs_rotator_if.master   sd,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      x_out,
    output logic [WIDTH-1:0]      y_out
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_i;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic [WIDTH-1:0]        r_vs;
    logic [WIDTH-1:0]        r_vc;
    logic [WIDTH-1:0]        r_x_out;
    logic [WIDTH-1:0]        r_y_out;

    logic                    w_d_pos;
    logic                    w_last;
    logic [WIDTH-1:0]        w_k;
    logic [WIDTH-1:0]        w_csa_sum;
    logic [WIDTH-1:0]        w_csa_carry;
    logic [WIDTH-1:0]        w_vc_next;
    logic signed [WIDTH-1:0] w_x_rot;
    logic signed [WIDTH-1:0] w_y_rot;
    logic signed [WIDTH-1:0] w_x_cmp;
    logic signed [WIDTH-1:0] w_y_cmp;

    // Z >= 0 (sign 0) rotates positively and subtracts the table angle.
    assign w_d_pos = ~sd.sd_sgn;
    assign w_last  = (r_i == 4'(ITER - 1));

    // Subtraction is ~ATAN plus a +1 injected into the free carry LSB.
    assign w_k       = w_d_pos ? ~WIDTH'(atan_q14(r_i)) : WIDTH'(atan_q14(r_i));
    assign w_vc_next = (w_csa_carry << 1) | WIDTH'(w_d_pos);

    csa32 #(
        .WIDTH (WIDTH)
    ) u_csa32 (
        .a     (r_vs),
        .b     (r_vc),
        .c     (w_k),
        .sum   (w_csa_sum),
        .carry (w_csa_carry)
    );

    assign w_x_rot = w_d_pos ? (r_x - (r_y >>> r_i)) : (r_x + (r_y >>> r_i));
    assign w_y_rot = w_d_pos ? (r_y + (r_x >>> r_i)) : (r_y - (r_x >>> r_i));

    // Shift-add approximation of 1/1.64676.
    assign w_x_cmp = (r_x >>> 1) + (r_x >>> 3) - (r_x >>> 6) - (r_x >>> 9);
    assign w_y_cmp = (r_y >>> 1) + (r_y >>> 3) - (r_y >>> 6) - (r_y >>> 9);

    assign sd.sd_vs = r_vs;
    assign sd.sd_vc = r_vc;
    assign x_out    = r_x_out;
    assign y_out    = r_y_out;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        w_state_next = r_state;
        sd.sd_valid  = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                sd.sd_valid  = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (sd.sd_done) begin
`ifdef SCALE_COMP_EN
                    w_state_next = w_last ? COMP : SEND;
`else
                    w_state_next = w_last ? DONE : SEND;
`endif
                end
            end
            COMP: begin
                w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand load, micro-rotation and result capture on entry to DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_i     <= 4'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_vs    <= '0;
            r_vc    <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x  <= x_in;
                        r_y  <= y_in;
                        r_vs <= z_in;
                        r_vc <= '0;
                        r_i  <= 4'd0;
                    end
                end
                WAIT: begin
                    if (sd.sd_done) begin
                        r_x  <= w_x_rot;
                        r_y  <= w_y_rot;
                        r_vs <= w_csa_sum;
                        r_vc <= w_vc_next;
                        r_i  <= r_i + 4'd1;
`ifndef SCALE_COMP_EN
                        if (w_last) begin
                            r_x_out <= w_x_rot;
                            r_y_out <= w_y_rot;
                        end
`endif
                    end
                end
                COMP: begin
                    r_x     <= w_x_cmp;
                    r_y     <= w_y_cmp;
                    r_x_out <= w_x_cmp;
                    r_y_out <= w_y_cmp;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cordic_cs_rotator.sv
//------------------------------------------------------------------------------
// Module   : tb_cordic_cs_rotator
// Brief    : Self-checking bench for cordic_cs_rotator with a 1-cycle sign
//            detector model (optional extra stall) and a result scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cordic_cs_rotator;

    localparam int WIDTH = 16;
    localparam int ITER  = 12;
`ifdef SCALE_COMP_EN
    localparam int C_BASE_LAT = 27;
    localparam int C_X0       = 16384;
    localparam int C_TOL      = 12;
`else
    localparam int C_BASE_LAT = 26;
    localparam int C_X0       = 9949;
    localparam int C_TOL      = 8;
`endif

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        int          ex;
        int          ey;
        int          stall;
    } vec_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x_in  = '0;
    logic [15:0] y_in  = '0;
    logic [15:0] z_in  = '0;
    logic        busy;
    logic        done;
    logic [15:0] x_out;
    logic [15:0] y_out;

    int n_tests = 0;
    int n_fail  = 0;

    int          atan_tb [12] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8};
    logic [15:0] ref_z [ITER];
    exp_t        sb_q [$];
    vec_t        vecs [5];

    int          send_idx = 0;
    int          stall_n  = 0;
    logic        in_wait  = 1'b0;
    logic [15:0] hold_vs  = '0;
    logic [15:0] hold_vc  = '0;
    logic        det_pend = 1'b0;
    int          det_cnt  = 0;
    logic [15:0] det_sum;

    cordic_cs_rotator_if #(.WIDTH(WIDTH)) sd_if ();

    cordic_cs_rotator #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .sd    (sd_if),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out)
    );

    always #5 clk = ~clk;

    assign det_sum = sd_if.sd_vs + sd_if.sd_vc;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        int diff;
        n_tests++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Sign detector: registers the sign of VS+VC, reports it stall_n cycles late.
    always @(posedge clk) begin
        if (!reset) begin
            sd_if.sd_done <= 1'b0;
            sd_if.sd_sgn  <= 1'b0;
            det_pend      <= 1'b0;
            det_cnt       <= 0;
        end else begin
            sd_if.sd_done <= 1'b0;
            if (det_pend) begin
                if (det_cnt == 0) begin
                    sd_if.sd_done <= 1'b1;
                    det_pend      <= 1'b0;
                end else begin
                    det_cnt <= det_cnt - 1;
                end
            end else if (sd_if.sd_valid) begin
                sd_if.sd_sgn <= det_sum[15];
                if (stall_n == 0) begin
                    sd_if.sd_done <= 1'b1;
                end else begin
                    det_pend <= 1'b1;
                    det_cnt  <= stall_n - 1;
                end
            end
        end
    end

    // Residual at each SEND against the reference, and hold during WAIT.
    always @(negedge clk) begin
        if (!reset) begin
            in_wait = 1'b0;
        end else if (sd_if.sd_valid) begin
            check("send_in_range", int'(send_idx < ITER), 1);
            if (send_idx < ITER) begin
                check("send_residual", int'(det_sum), int'(ref_z[send_idx]));
            end
            send_idx++;
            hold_vs = sd_if.sd_vs;
            hold_vc = sd_if.sd_vc;
            in_wait = 1'b1;
        end else if (in_wait) begin
            check("wait_vs_stable", int'(sd_if.sd_vs), int'(hold_vs));
            check("wait_vc_stable", int'(sd_if.sd_vc), int'(hold_vc));
            if (sd_if.sd_done) in_wait = 1'b0;
        end
    end

    task automatic ref_model(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] z0,
                             output logic [15:0] rx, output logic [15:0] ry);
        logic signed [15:0] x, y, z, xt;
        x = x0;
        y = y0;
        z = z0;
        for (int i = 0; i < ITER; i++) begin
            ref_z[i] = z;
            xt = x;
            if (z >= 0) begin
                x = x - (y >>> i);
                y = y + (xt >>> i);
                z = z - 16'(atan_tb[i]);
            end else begin
                x = x + (y >>> i);
                y = y - (xt >>> i);
                z = z + 16'(atan_tb[i]);
            end
        end
`ifdef SCALE_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
        y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9);
`endif
        rx = x;
        ry = y;
    endtask

    task automatic kick(input vec_t v);
        exp_t e;
        ref_model(v.x, v.y, v.z, e.x, e.y);
        sb_q.push_back(e);
        send_idx = 0;
        stall_n  = v.stall;
        @(posedge clk); #1;
        x_in  = v.x;
        y_in  = v.y;
        z_in  = v.z;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit inject);
        exp_t e;
        int   edges;
        bit   seen;
        kick(v);
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (inject && edges == 6) begin
                    start = 1'b1;
                    x_in  = 16'h1234;
                    z_in  = 16'h0800;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                edges++;
            end
        end
        start = 1'b0;
        check("done_seen", int'(seen), 1);
        e = sb_q.pop_front();
        if (seen) begin
            check("latency", edges + 1, C_BASE_LAT + ITER * v.stall);
            check("x_exact", int'(x_out), int'(e.x));
            check("y_exact", int'(y_out), int'(e.y));
            check_tol("x_approx", int'($signed(x_out)), v.ex, C_TOL);
            check_tol("y_approx", int'($signed(y_out)), v.ey, C_TOL);
            if (inject) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("done_one_cycle", int'(done), 0);
            check("idle_after_done", int'(busy), 0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sd_vs"},    int'(sd_if.sd_vs),    0);
        check({tag, "_sd_vc"},    int'(sd_if.sd_vc),    0);
        check({tag, "_sd_valid"}, int'(sd_if.sd_valid), 0);
        check({tag, "_busy"},     int'(busy),           0);
        check({tag, "_done"},     int'(done),           0);
        check({tag, "_x_out"},    int'(x_out),          0);
        check({tag, "_y_out"},    int'(y_out),          0);
    endtask

    task automatic reset_mid(input vec_t v);
        int  cyc;
        bit  seen;
        exp_t e;
        kick(v);
        cyc = 0;
        while (send_idx < 5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_iter5", send_idx, 5);
        reset = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("midreset");
        reset = 1'b1;
        e = sb_q.pop_back();
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("no_done_after_reset", int'(seen), 0);
    endtask

    initial begin
        vecs[0] = '{16'(C_X0), 16'd0, 16'd0,         16384,  0,     0};
        vecs[1] = '{16'(C_X0), 16'd0, 16'd12868,     11585,  11585, 0};
        vecs[2] = '{16'(C_X0), 16'd0, 16'(-8579),    14189, -8192,  0};
        vecs[3] = '{16'(C_X0), 16'd0, 16'(-8579),    14189, -8192,  3};
        vecs[4] = '{16'(C_X0), 16'd0, 16'd8579,      14189,  8192,  0};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], 1'b0);
        end

        // start pulses while busy and on the done cycle must be ignored.
        run_vec(vecs[1], 1'b1);

        // Reset mid-flight discards the result; a fresh start then completes.
        reset_mid(vecs[2]);
        run_vec(vecs[4], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
